// File: rtl/riscv_tb_pkg.sv
// Shared types and widths for the run monitor and its trace FIFO.
package riscv_tb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RSTSEQ = 2'd1,
        ST_RUN    = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam int RD_W = 5;

    // One trace entry is {pc, rd, write_data}.
    function automatic int trace_width(input int xlen);
        return xlen + RD_W + xlen;
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// First-word-fall-through FIFO holding the writeback trace.
// A push while full is accepted only if a pop frees a slot on the same edge.
module trace_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_clr,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic [WIDTH-1:0]           i_din,
    output logic [WIDTH-1:0]           o_dout,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CW'(DEPTH));
    assign w_pop   = i_pop && !o_empty;
    assign w_push  = i_push && (!o_full || w_pop);
    assign o_dout  = r_mem[r_rd_ptr];
    assign o_count = r_count;

    // Storage write; pointers alone define validity so no reset is needed here.
    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_din;
    end

    // Pointer and occupancy tracking; pointers wrap naturally at DEPTH (power of 2).
    always_ff @(posedge i_clk) begin
        if (i_reset || i_clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_push && !w_pop)      r_count <= r_count + CW'(1);
            else if (!w_push && w_pop) r_count <= r_count - CW'(1);
        end
    end

endmodule

// File: rtl/riscv_run_monitor.sv
// Run controller and commit monitor: sequences CPU reset, watches PC for a
// self-loop halt or timeout, and records register writebacks into a trace FIFO.
module riscv_run_monitor
    import riscv_tb_pkg::*;
#(
    parameter int XLEN         = 64,
    parameter int RESET_CYCLES = 2,
    parameter int TRACE_DEPTH  = 16,
    parameter int HALT_REPEAT  = 4,
    parameter int TIMEOUT      = 1024
) (
    input  logic                             i_clk,
    input  logic                             i_reset,
    input  logic                             i_start,
    output logic                             o_cpu_reset,
    input  logic [XLEN-1:0]                  i_pc,
    input  logic                             i_reg_write,
    input  logic [4:0]                       i_rd,
    input  logic [XLEN-1:0]                  i_write_data,
    input  logic                             i_trace_rd_en,
    output logic                             o_trace_valid,
    output logic [XLEN-1:0]                  o_trace_pc,
    output logic [4:0]                       o_trace_rd,
    output logic [XLEN-1:0]                  o_trace_data,
    output logic [$clog2(TRACE_DEPTH+1)-1:0] o_trace_count,
    output logic                             o_trace_overflow,
    output logic [1:0]                       o_state,
    output logic                             o_done,
    output logic                             o_timeout,
    output logic [31:0]                      o_cycle_count,
    output logic [31:0]                      o_wb_count
);
    localparam int TW  = trace_width(XLEN);
    localparam int RCW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam int RPW = $clog2(HALT_REPEAT + 1);

    state_t          r_state;
    logic            r_cpu_reset;
    logic            r_done;
    logic            r_timeout;
    logic            r_overflow;
    logic [31:0]     r_cycle;
    logic [31:0]     r_wb;
    logic [RCW-1:0]  r_rst_cnt;
    logic [RPW-1:0]  r_rep;
    logic [XLEN-1:0] r_prev_pc;
    logic            r_prev_vld;

    logic            w_begin;
    logic            w_push_req;
    logic            w_drop;
    logic            w_full;
    logic            w_empty;
    logic [TW-1:0]   w_head;
    logic [31:0]     w_cyc_next;
    logic [31:0]     w_wb_next;
    logic [RPW-1:0]  w_rep_next;
    logic            w_halt;
    logic            w_tmo;

    assign w_begin    = i_start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_push_req = (r_state == ST_RUN) && i_reg_write && (i_rd != 5'd0);
    assign w_drop     = w_push_req && w_full && !i_trace_rd_en;
    assign w_cyc_next = (r_cycle == '1) ? r_cycle : r_cycle + 32'd1;
    assign w_wb_next  = (r_wb == '1) ? r_wb : r_wb + 32'd1;
    assign w_rep_next = (r_prev_vld && (i_pc == r_prev_pc)) ? r_rep + RPW'(1) : '0;
    assign w_halt     = (w_rep_next == RPW'(HALT_REPEAT));
    assign w_tmo      = (w_cyc_next >= 32'(TIMEOUT));

    trace_fifo #(
        .WIDTH (TW),
        .DEPTH (TRACE_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_clr   (w_begin),
        .i_push  (w_push_req),
        .i_pop   (i_trace_rd_en),
        .i_din   ({i_pc, i_rd, i_write_data}),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (o_trace_count)
    );

    // Run FSM with its counters, halt detector and registered status outputs.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= ST_IDLE;
            r_cpu_reset <= 1'b1;
            r_done      <= 1'b0;
            r_timeout   <= 1'b0;
            r_cycle     <= '0;
            r_wb        <= '0;
            r_rst_cnt   <= '0;
            r_rep       <= '0;
            r_prev_pc   <= '0;
            r_prev_vld  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (i_start) begin
                        r_state     <= ST_RSTSEQ;
                        r_cpu_reset <= 1'b1;
                        r_done      <= 1'b0;
                        r_timeout   <= 1'b0;
                        r_cycle     <= '0;
                        r_wb        <= '0;
                        r_rst_cnt   <= '0;
                        r_rep       <= '0;
                        r_prev_vld  <= 1'b0;
                    end
                end
                ST_RSTSEQ: begin
                    if (r_rst_cnt == RCW'(RESET_CYCLES - 1)) begin
                        r_state     <= ST_RUN;
                        r_cpu_reset <= 1'b0;
                    end else begin
                        r_rst_cnt <= r_rst_cnt + RCW'(1);
                    end
                end
                ST_RUN: begin
                    r_cycle    <= w_cyc_next;
                    r_prev_pc  <= i_pc;
                    r_prev_vld <= 1'b1;
                    r_rep      <= w_rep_next;
                    if (w_push_req) r_wb <= w_wb_next;
                    // Timeout takes precedence when both fire on one edge.
                    if (w_tmo || w_halt) begin
                        r_state   <= ST_DONE;
                        r_done    <= 1'b1;
                        r_timeout <= w_tmo;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Sticky flag for writebacks lost because the trace was full.
    always_ff @(posedge i_clk) begin
        if (i_reset || w_begin) r_overflow <= 1'b0;
        else if (w_drop)        r_overflow <= 1'b1;
    end

    assign o_cpu_reset      = r_cpu_reset;
    assign o_state          = r_state;
    assign o_done           = r_done;
    assign o_timeout        = r_timeout;
    assign o_cycle_count    = r_cycle;
    assign o_wb_count       = r_wb;
    assign o_trace_overflow = r_overflow;
    assign o_trace_valid    = !w_empty;
    assign o_trace_pc       = w_empty ? '0 : w_head[TW-1 -: XLEN];
    assign o_trace_rd       = w_empty ? '0 : w_head[XLEN+4 : XLEN];
    assign o_trace_data     = w_empty ? '0 : w_head[XLEN-1:0];

endmodule

// File: tb/tb_riscv_run_monitor.sv
// Self-checking bench for riscv_run_monitor: directed table, corner sequences,
// and randomized runs compared against a queue-based reference model.
module tb_riscv_run_monitor;
    localparam int XLEN    = 64;
    localparam int DEPTH   = 16;
    localparam int HREP    = 4;
    localparam int TIMEOUT = 1024;

    logic        clk = 1'b0;
    logic        reset, start, reg_write, rd_en;
    logic [63:0] pc, wdata;
    logic [4:0]  rd;

    logic        cpu_reset, t_valid, t_ovf, done, tmo;
    logic [63:0] t_pc, t_data;
    logic [4:0]  t_rd, t_cnt;
    logic [1:0]  state;
    logic [31:0] cyc_cnt, wb_cnt;

    always #5 clk = ~clk;

    riscv_run_monitor #(
        .XLEN(XLEN), .RESET_CYCLES(2), .TRACE_DEPTH(DEPTH),
        .HALT_REPEAT(HREP), .TIMEOUT(TIMEOUT)
    ) dut (
        .i_clk(clk), .i_reset(reset), .i_start(start), .o_cpu_reset(cpu_reset),
        .i_pc(pc), .i_reg_write(reg_write), .i_rd(rd), .i_write_data(wdata),
        .i_trace_rd_en(rd_en), .o_trace_valid(t_valid), .o_trace_pc(t_pc),
        .o_trace_rd(t_rd), .o_trace_data(t_data), .o_trace_count(t_cnt),
        .o_trace_overflow(t_ovf), .o_state(state), .o_done(done),
        .o_timeout(tmo), .o_cycle_count(cyc_cnt), .o_wb_count(wb_cnt)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic restart();
        start = 1'b1; reg_write = 1'b0; rd_en = 1'b0;
        cyc();
        start = 1'b0;
        cyc();
        cyc();
    endtask

    // Directed table: one RUN cycle per record.
    typedef struct {
        logic [63:0] pc;
        logic        we;
        logic [4:0]  rd;
        logic [63:0] data;
        logic [1:0]  st;
        logic        dn;
        logic [4:0]  cnt;
    } vec_t;
    vec_t tbl[7];

    // Reference model state.
    typedef struct {
        logic [63:0] pc;
        logic [4:0]  rd;
        logic [63:0] d;
    } ent_t;
    ent_t        m_q[$];
    logic [63:0] m_hist[$];
    int          m_wb, m_cyc;
    bit          m_ovf, m_dn;

    task automatic model_step(input bit in_run);
        int   pre;
        bit   popd, pushit, h;
        ent_t e;
        pre    = m_q.size();
        popd   = rd_en && (pre > 0);
        pushit = 1'b0;
        if (in_run) begin
            if (reg_write && rd != 5'd0) begin
                m_wb++;
                if (pre < DEPTH || popd) pushit = 1'b1;
                else                     m_ovf = 1'b1;
            end
            m_hist.push_back(pc);
            m_cyc++;
            h = (m_hist.size() > HREP);
            if (h)
                for (int k = 1; k <= HREP; k++)
                    if (m_hist[m_hist.size()-1-k] != pc) h = 1'b0;
            if (h || m_cyc >= TIMEOUT) m_dn = 1'b1;
        end
        if (popd) void'(m_q.pop_front());
        if (pushit) begin
            e.pc = pc; e.rd = rd; e.d = wdata;
            m_q.push_back(e);
        end
    endtask

    task automatic model_check();
        chk("rnd count", t_cnt, m_q.size());
        chk("rnd valid", t_valid, m_q.size() != 0);
        chk("rnd head pc", t_pc, m_q.size() ? m_q[0].pc : 64'd0);
        chk("rnd head rd", t_rd, m_q.size() ? m_q[0].rd : 5'd0);
        chk("rnd head data", t_data, m_q.size() ? m_q[0].d : 64'd0);
        chk("rnd wb_count", wb_cnt, m_wb);
        chk("rnd cycle_count", cyc_cnt, m_cyc);
        chk("rnd overflow", t_ovf, m_ovf);
        chk("rnd done", done, m_dn);
        chk("rnd state", state, m_dn ? 2'd3 : 2'd2);
    endtask

    initial begin
        int n;
        logic [63:0] cur;

        tbl[0] = '{64'd0, 1'b1, 5'd1, 64'hA, 2'd2, 1'b0, 5'd1};
        tbl[1] = '{64'd4, 1'b1, 5'd0, 64'hB, 2'd2, 1'b0, 5'd1};
        tbl[2] = '{64'd8, 1'b1, 5'd5, 64'hC, 2'd2, 1'b0, 5'd2};
        tbl[3] = '{64'd8, 1'b0, 5'd0, 64'h0, 2'd2, 1'b0, 5'd2};
        tbl[4] = '{64'd8, 1'b0, 5'd0, 64'h0, 2'd2, 1'b0, 5'd2};
        tbl[5] = '{64'd8, 1'b0, 5'd0, 64'h0, 2'd2, 1'b0, 5'd2};
        tbl[6] = '{64'd8, 1'b0, 5'd0, 64'h0, 2'd3, 1'b1, 5'd2};

        reset = 1'b1; start = 1'b0; reg_write = 1'b0; rd_en = 1'b0;
        pc = '0; wdata = '0; rd = '0;
        cyc();
        start = 1'b1;          // reset must win over start
        cyc();
        reset = 1'b0; start = 1'b0;
        chk("reset state", state, 2'd0);
        chk("reset cpu_reset", cpu_reset, 1'b1);
        chk("reset done", done, 1'b0);
        chk("reset valid", t_valid, 1'b0);
        chk("reset cycle", cyc_cnt, 32'd0);
        chk("reset wb", wb_cnt, 32'd0);

        // Reset sequencing.
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("rstseq1 state", state, 2'd1);
        chk("rstseq1 cpu_reset", cpu_reset, 1'b1);
        cyc();
        chk("rstseq2 state", state, 2'd1);
        chk("rstseq2 cpu_reset", cpu_reset, 1'b1);
        cyc();
        chk("run state", state, 2'd2);
        chk("run cpu_reset", cpu_reset, 1'b0);

        // Halt on PC self-loop plus writeback filtering.
        for (int i = 0; i < 7; i++) begin
            pc = tbl[i].pc; reg_write = tbl[i].we; rd = tbl[i].rd; wdata = tbl[i].data;
            cyc();
            chk("tbl state", state, tbl[i].st);
            chk("tbl done", done, tbl[i].dn);
            chk("tbl cycle", cyc_cnt, i + 1);
            chk("tbl count", t_cnt, tbl[i].cnt);
        end
        reg_write = 1'b0;
        chk("halt timeout", tmo, 1'b0);
        chk("halt cpu_reset", cpu_reset, 1'b0);
        chk("wb2 count", wb_cnt, 32'd2);
        chk("pop0 rd", t_rd, 5'd1);
        chk("pop0 data", t_data, 64'hA);
        chk("pop0 pc", t_pc, 64'd0);
        rd_en = 1'b1;
        cyc();
        chk("pop1 rd", t_rd, 5'd5);
        chk("pop1 data", t_data, 64'hC);
        chk("pop1 pc", t_pc, 64'd8);
        cyc();
        chk("pop2 valid", t_valid, 1'b0);
        chk("pop2 data", t_data, 64'd0);
        cyc();
        chk("pop empty count", t_cnt, 5'd0);
        rd_en = 1'b0;

        // Overflow: 18 pushes into 16 slots, then push+pop while full.
        restart();
        chk("restart count", t_cnt, 5'd0);
        chk("restart wb", wb_cnt, 32'd0);
        chk("restart done", done, 1'b0);
        for (int i = 0; i < 18; i++) begin
            pc = 64'(100 + 4 * i); reg_write = 1'b1; rd = 5'((i % 31) + 1); wdata = 64'(i);
            cyc();
        end
        chk("ovf count", t_cnt, 5'd16);
        chk("ovf flag", t_ovf, 1'b1);
        chk("ovf head pc", t_pc, 64'd100);
        chk("ovf head data", t_data, 64'd0);
        chk("ovf wb", wb_cnt, 32'd18);
        pc = 64'd172; rd = 5'd7; wdata = 64'h99; rd_en = 1'b1;
        cyc();
        rd_en = 1'b0; reg_write = 1'b0;
        chk("full pushpop count", t_cnt, 5'd16);
        chk("full pushpop head", t_data, 64'd1);
        chk("full pushpop wb", wb_cnt, 32'd19);
        n = 0;
        while (!done && n < 10) begin cyc(); n++; end
        chk("ovf halt state", state, 2'd3);
        chk("ovf halt cycle", cyc_cnt, 32'd23);

        // Timeout with an ever-advancing PC.
        restart();
        chk("tmo start ovf", t_ovf, 1'b0);
        chk("tmo start count", t_cnt, 5'd0);
        n = 0;
        while (!done && n < 1100) begin
            pc = 64'(4 * n);
            cyc();
            n++;
        end
        chk("tmo cycles", n, TIMEOUT);
        chk("tmo cycle_count", cyc_cnt, TIMEOUT);
        chk("tmo flag", tmo, 1'b1);
        cyc();
        chk("tmo hold cycle", cyc_cnt, TIMEOUT);
        chk("tmo hold done", done, 1'b1);

        // Randomized runs against the reference model.
        for (int r = 0; r < 4; r++) begin
            restart();
            m_q.delete(); m_hist.delete();
            m_wb = 0; m_cyc = 0; m_ovf = 1'b0; m_dn = 1'b0;
            cur = 64'd0;
            for (int i = 0; i < 90 && !m_dn; i++) begin
                if (i < 60) cur = 64'($urandom_range(3) * 4);
                pc = cur;
                reg_write = $urandom_range(1);
                rd = 5'($urandom_range(3));
                wdata = {$urandom(), $urandom()};
                rd_en = ($urandom_range(2) == 0);
                model_step(1'b1);
                cyc();
                model_check();
            end
            for (int i = 0; i < 6; i++) begin
                reg_write = 1'b1; rd = 5'd3; rd_en = 1'b1;
                model_step(1'b0);
                cyc();
                model_check();
            end
            rd_en = 1'b0; reg_write = 1'b0;
        end

        // Reset in the middle of a run with entries queued.
        restart();
        for (int i = 0; i < 3; i++) begin
            pc = 64'(200 + 4 * i); reg_write = 1'b1; rd = 5'd2; wdata = 64'(i + 7);
            cyc();
        end
        reg_write = 1'b0;
        chk("mid count", t_cnt, 5'd3);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk("mid rst state", state, 2'd0);
        chk("mid rst cpu_reset", cpu_reset, 1'b1);
        chk("mid rst cycle", cyc_cnt, 32'd0);
        chk("mid rst wb", wb_cnt, 32'd0);
        chk("mid rst valid", t_valid, 1'b0);
        restart();
        chk("post state", state, 2'd2);
        chk("post count", t_cnt, 5'd0);
        chk("post done", done, 1'b0);
        chk("post timeout", tmo, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
